// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the display scan blocks.
//   seg_state_e : scan phase (ST_BLANK guard, ST_DRIVE digit lit)
//   SEG_OFF     : all segments dark on an active-low bus
//   DIG_OFF     : no digit selected on an active-low bus
//   HEX_SEG     : hex nibble -> active-high {g,f,e,d,c,b,a}, shapes 0-9 A b C d E F
package seg_pkg;

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } seg_state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] DIG_OFF = 4'hF;

  // Entry 15 first, entry 0 last.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: combinational hex nibble to seven-segment pattern.
// Ports:
//   i_nibble [3:0] : value 0..F
//   o_seg    [6:0] : active-high {g,f,e,d,c,b,a}
// Polarity inversion and decimal point are left to the instantiating block.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: four-digit multiplexed seven-segment (+dp) scan controller.
// Frames arrive over a valid/ready handshake into a one-deep pending
// register and are promoted to the active register only at a frame
// boundary (first BLANK cycle of digit 0), so a frame is never torn.
// Optional macro SEG_SCAN_DIMMING_EN: PWM the lit part of each DRIVE phase
// according to brightness (sampled at each frame boundary).
// Ports:
//   clk, reset_n      : clock, synchronous active-low reset
//   frame_valid/ready : frame handshake
//   frame_data [15:0] : digit n = bits [4n+3:4n]
//   frame_dp   [3:0]  : decimal point per digit, 1 = lit
//   frame_blank[3:0]  : 1 = digit dark
//   brightness [3:0]  : duty 0 = 1/16 .. 15 = full (dimming build only)
//   seg_out    [7:0]  : {dp,g,f,e,d,c,b,a}, active-low
//   dig_sel    [3:0]  : digit selects, active-low
//   frame_start       : one-cycle pulse at each frame boundary
//
// state    | meaning
// ST_BLANK | guard period, all outputs off
// ST_DRIVE | digit idx selected and segments driven
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV      = 16384,
  parameter int BLANK_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [15:0] frame_data,
  input  logic [3:0]  frame_dp,
  input  logic [3:0]  frame_blank,
  input  logic [3:0]  brightness,
  output logic [7:0]  seg_out,
  output logic [3:0]  dig_sel,
  output logic        frame_start
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(CLK_DIV - 1);

  seg_state_e  r_state;
  logic [1:0]  r_idx;
  logic [CW-1:0] r_slot_cnt;

  logic [15:0] r_pend_data;
  logic [3:0]  r_pend_dp;
  logic [3:0]  r_pend_blank;
  logic        r_pend_full;

  logic [15:0] r_act_data;
  logic [3:0]  r_act_dp;
  logic [3:0]  r_act_blank;

  logic [7:0]  r_seg_out;
  logic [3:0]  r_dig_sel;
  logic        r_frame_start;

  logic        w_boundary;
  logic        w_xfer;
  logic        w_lit;
  logic [3:0]  w_nibble;
  logic [6:0]  w_seg7;

  assign w_boundary = (r_state == ST_BLANK) && (r_idx == 2'd0) && (r_slot_cnt == '0);
  assign w_xfer     = frame_valid && !r_pend_full;
  assign w_nibble   = r_act_data[{r_idx, 2'b00} +: 4];

  seg_hex_decoder u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_seg7)
  );

`ifdef SEG_SCAN_DIMMING_EN
  localparam logic [31:0] DUTY_STEP = 32'((CLK_DIV - BLANK_CYCLES) / 16);

  logic [3:0]    r_bright;
  logic [CW-1:0] w_drive_cnt;

  // Slot counter keeps running through DRIVE, so elapsed DRIVE cycles are an offset of it.
  assign w_drive_cnt = r_slot_cnt - CW'(BLANK_CYCLES);
  assign w_lit = 32'(w_drive_cnt) < ((32'(r_bright) + 32'd1) * DUTY_STEP);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bright <= 4'hF;
    end else if (w_boundary) begin
      r_bright <= brightness;
    end
  end
`else
  logic w_unused_brightness;
  assign w_unused_brightness = ^brightness;
  assign w_lit = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_BLANK;
      r_idx         <= 2'd0;
      r_slot_cnt    <= '0;
      r_pend_data   <= 16'h0;
      r_pend_dp     <= 4'h0;
      r_pend_blank  <= 4'h0;
      r_pend_full   <= 1'b0;
      r_act_data    <= 16'h0;
      r_act_dp      <= 4'h0;
      r_act_blank   <= 4'hF;
      r_seg_out     <= SEG_OFF;
      r_dig_sel     <= DIG_OFF;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_boundary;
      r_slot_cnt    <= (r_slot_cnt == SLOT_LAST) ? '0 : r_slot_cnt + 1'b1;

      case (r_state)
        ST_BLANK: begin
          r_dig_sel <= DIG_OFF;
          r_seg_out <= SEG_OFF;
          if (r_slot_cnt == BLANK_LAST) r_state <= ST_DRIVE;
        end
        ST_DRIVE: begin
          r_dig_sel <= DIG_OFF ^ (4'b0001 << r_idx);
          if (r_act_blank[r_idx] || !w_lit) r_seg_out <= SEG_OFF;
          else                              r_seg_out <= ~{r_act_dp[r_idx], w_seg7};
          if (r_slot_cnt == SLOT_LAST) begin
            r_state <= ST_BLANK;
            r_idx   <= r_idx + 2'd1;
          end
        end
        default: r_state <= ST_BLANK;
      endcase

      // A transfer needs pend empty, and a copy needs it full, so the two never collide.
      if (w_xfer) begin
        r_pend_data  <= frame_data;
        r_pend_dp    <= frame_dp;
        r_pend_blank <= frame_blank;
        r_pend_full  <= 1'b1;
      end else if (w_boundary && r_pend_full) begin
        r_act_data  <= r_pend_data;
        r_act_dp    <= r_pend_dp;
        r_act_blank <= r_pend_blank;
        r_pend_full <= 1'b0;
      end
    end
  end

  assign frame_ready = !r_pend_full;
  assign seg_out     = r_seg_out;
  assign dig_sel     = r_dig_sel;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  localparam int CLK_DIV = 64;
  localparam int BLANK_CYCLES = 16;
  localparam int FRAME = 4 * CLK_DIV;
  localparam int STEP = (CLK_DIV - BLANK_CYCLES) / 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [15:0] frame_data = 16'h0;
  logic [3:0]  frame_dp = 4'h0;
  logic [3:0]  frame_blank = 4'h0;
  logic [3:0]  brightness = 4'hF;
  logic [7:0]  seg_out;
  logic [3:0]  dig_sel;
  logic        frame_start;

  int n_total = 0;
  int n_pass = 0;

  seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_CYCLES)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_dp    (frame_dp),
    .frame_blank (frame_blank),
    .brightness  (brightness),
    .seg_out     (seg_out),
    .dig_sel     (dig_sel),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input bit ok, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Behavioural model: outputs follow from cycle position within the frame.
  logic [6:0] tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  bit          model_on = 0;
  int          k;
  bit          m_full;
  logic [15:0] m_pdata, m_adata;
  logic [3:0]  m_pdp, m_pblank, m_adp, m_ablank, m_bright;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_dig;
  logic        exp_fs, exp_ready;

  always @(posedge clk) begin
    int p, pos, slot;
    logic [3:0] nib;
    bit lit;
    if (!reset_n) begin
      model_on = 1; k = 0; m_full = 0;
      m_pdata = 0; m_pdp = 0; m_pblank = 0;
      m_adata = 0; m_adp = 0; m_ablank = 4'hF; m_bright = 4'hF;
      exp_seg = 8'hFF; exp_dig = 4'hF; exp_fs = 0; exp_ready = 1;
    end else begin
      p = k % FRAME; pos = p % CLK_DIV; slot = p / CLK_DIV;
      exp_fs = (p == 0);
      if (pos < BLANK_CYCLES) begin
        exp_dig = 4'hF; exp_seg = 8'hFF;
      end else begin
        exp_dig = 4'hF & ~(4'b0001 << slot);
        nib = 4'((m_adata >> (4 * slot)) & 16'hF);
        lit = 1;
`ifdef SEG_SCAN_DIMMING_EN
        lit = (pos - BLANK_CYCLES) < (int'(m_bright) + 1) * STEP;
`endif
        exp_seg = (m_ablank[slot] || !lit) ? 8'hFF : ~{m_adp[slot], tab[nib]};
      end
      if (frame_valid && !m_full) begin
        m_pdata = frame_data; m_pdp = frame_dp; m_pblank = frame_blank; m_full = 1;
      end else if (p == 0 && m_full) begin
        m_adata = m_pdata; m_adp = m_pdp; m_ablank = m_pblank; m_full = 0;
      end
      if (p == 0) m_bright = brightness;
      exp_ready = !m_full;
      k++;
    end
  end

  always @(negedge clk) begin
    if (model_on)
      check("cycle", {seg_out, dig_sel, frame_start, frame_ready} == {exp_seg, exp_dig, exp_fs, exp_ready},
            {18'h0, seg_out, dig_sel, frame_start, frame_ready},
            {18'h0, exp_seg, exp_dig, exp_fs, exp_ready});
  end

  task automatic wait_dig(input logic [3:0] pat);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (dig_sel == pat) return;
    end
    check("wait_dig_timeout", 0, {28'h0, dig_sel}, {28'h0, pat});
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (frame_start) return;
    end
    check("wait_fs_timeout", 0, 0, 1);
  endtask

  task automatic send(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                      input bit hold, output logic fs_at_accept);
    bit done = 0;
    fs_at_accept = 0;
    @(negedge clk);
    frame_data = d; frame_dp = dp; frame_blank = bl; frame_valid = 1;
    for (int i = 0; i < 1000 && !done; i++) begin
      if (frame_ready) begin
        fs_at_accept = frame_start;
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check("send_timeout", 0, 0, 1);
    if (!hold) begin
      @(negedge clk);
      frame_valid = 0;
    end
  endtask

  task automatic count_lit(input string name, input int d, input int exp);
    logic [3:0] pat;
    int cnt = 0;
    pat = 4'hF & ~(4'b0001 << d);
    wait_dig(4'hF);
    wait_dig(pat);
    for (int i = 0; i < 200 && dig_sel == pat; i++) begin
      if (seg_out != 8'hFF) cnt++;
      @(negedge clk);
    end
    check(name, cnt == exp, cnt, exp);
  endtask

  task automatic digit_seg(input string name, input int d, input logic [7:0] exp);
    wait_dig(4'hF & ~(4'b0001 << d));
    check(name, seg_out == exp, {24'h0, seg_out}, {24'h0, exp});
  endtask

  initial begin
    logic fs;
    int   n;
    int   dim3;

    repeat (4) @(negedge clk);
    check("rst_outputs", {seg_out, dig_sel, frame_start, frame_ready} == {8'hFF, 4'hF, 1'b0, 1'b1},
          {18'h0, seg_out, dig_sel, frame_start, frame_ready}, {18'h0, 8'hFF, 4'hF, 1'b0, 1'b1});
    reset_n = 1;

    // Idle scan: dark digits, fixed frame period.
    wait_fs();
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 1000);
    check("fs_period", n == FRAME, n, FRAME);
    digit_seg("idle_dig1_dark", 1, 8'hFF);
    count_lit("idle_drive_len", 3, 0);

    // Hex decode with decimal point.
    send(16'h12AF, 4'b0001, 4'b0000, 0, fs);
    wait_fs();
    digit_seg("hex_d0_F_dp", 0, 8'h0E);
    digit_seg("hex_d1_A", 1, 8'h88);
    digit_seg("hex_d2_2", 2, 8'hA4);
    digit_seg("hex_d3_1", 3, 8'hF9);

    // Duty measurement.
`ifdef SEG_SCAN_DIMMING_EN
    dim3 = 4 * STEP;
`else
    dim3 = CLK_DIV - BLANK_CYCLES;
`endif
    brightness = 4'd3;
    send(16'h8888, 4'b0000, 4'b0000, 0, fs);
    wait_fs();
    count_lit("duty_b3", 0, dim3);
    brightness = 4'd15;
    wait_fs();
    count_lit("duty_b15", 1, CLK_DIV - BLANK_CYCLES);

    // Back-to-back frames with valid held.
    send(16'h1234, 4'b0000, 4'b0000, 1, fs);
    send(16'h5678, 4'b0000, 4'b0000, 1, fs);
    check("b2b_accept_after_boundary", fs == 1'b1, {31'h0, fs}, 1);
    @(negedge clk);
    frame_valid = 0;
    digit_seg("b2b_first_d0", 0, 8'h99);
    wait_fs();
    digit_seg("b2b_second_d0", 0, 8'h80);

    // Blank mask on digit 2 keeps it selected but dark.
    send(16'h8888, 4'b0000, 4'b0100, 0, fs);
    wait_fs();
    digit_seg("blank_d0_lit", 0, 8'h80);
    count_lit("blank_d2_dark", 2, 0);

    // Reset mid-DRIVE with a pending frame.
    send(16'h1111, 4'b0000, 4'b0000, 0, fs);
    wait_dig(4'hD);
    reset_n = 0;
    @(negedge clk);
    check("rst_mid_drive", {seg_out, dig_sel, frame_ready} == {8'hFF, 4'hF, 1'b1},
          {19'h0, seg_out, dig_sel, frame_ready}, {19'h0, 8'hFF, 4'hF, 1'b1});
    @(negedge clk);
    reset_n = 1;
    wait_fs();
    wait_fs();
    count_lit("rst_pend_dropped", 0, 0);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
